// File: rtl/comalg_pkg.sv
// Shared com_alg definitions: sequencer opcodes, branch conditions, com_alg modes and
// sequencer state encodings.
package comalg_pkg;

    localparam logic [2:0] OP_EXEC  = 3'b000;
    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_LDCNT = 3'b010;
    localparam logic [2:0] OP_DJNZ  = 3'b011;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_ZERO   = 2'd1;
    localparam logic [1:0] COND_CARRY  = 2'd2;
    localparam logic [1:0] COND_ODD    = 2'd3;

    // Bit positions inside the {odd, carry, zero} status vector
    localparam int unsigned STAT_ZERO  = 0;
    localparam int unsigned STAT_CARRY = 1;
    localparam int unsigned STAT_ODD   = 2;

    localparam logic [5:0] MODE_ADD  = 6'b000000;
    localparam logic [5:0] MODE_SUB  = 6'b000001;
    localparam logic [5:0] MODE_SHL  = 6'b000010;
    localparam logic [5:0] MODE_SHR  = 6'b000011;
    localparam logic [5:0] MODE_CMP  = 6'b000100;
    localparam logic [5:0] MODE_MOV  = 6'b000101;
    localparam logic [5:0] MODE_SET0 = 6'b000110;
    localparam logic [5:0] MODE_SET1 = 6'b000111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWait,
        StDone,
        StErr
    } seq_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_EXEC) || (op == OP_BR) || (op == OP_LDCNT) ||
               (op == OP_DJNZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/comalg_seq_dec.sv
// Combinational field decode of the registered sequencer instruction.
module comalg_seq_dec
    import comalg_pkg::*;
#(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned CNT_W = 10
) (
    input  logic [15:0]      ir,
    output logic [2:0]       op,
    output logic [1:0]       cond,
    output logic             invert,
    output logic [PC_W-1:0]  target,
    output logic [CNT_W-1:0] count,
    output logic             illegal
);

    always_comb begin
        op      = ir[15:13];
        cond    = ir[12:11];
        invert  = ir[10];
        target  = ir[PC_W-1:0];
        count   = ir[CNT_W-1:0];
        illegal = !op_is_legal(ir[15:13]);
    end

endmodule

// File: rtl/comalg_seq.sv
// Micro-sequencer driving the com_alg command interface from an external program store.
// Optional watchdog on com_alg operations: define COMALG_SEQ_WDOG_EN.
module comalg_seq
    import comalg_pkg::*;
#(
    parameter int unsigned PC_W     = 5,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned WDOG_CYC = 1023
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seq_start,
    input  logic [7:0]      seq_wlen,
    output logic            seq_busy,
    output logic            seq_done,
    output logic            seq_error,
    output logic [PC_W-1:0] seq_pc,
    input  logic [15:0]     seq_instr,
    output logic [2:0]      seq_status,
    output logic [7:0]      comalg_wlen,
    output logic [5:0]      comalg_mode,
    output logic            comalg_start,
    input  logic            comalg_end,
    input  logic [2:0]      comalg_status
);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wlen_q, wlen_d;
    logic [5:0]       mode_q, mode_d;
    logic [2:0]       status_q, status_d;

    logic [2:0]       dec_op;
    logic [1:0]       dec_cond;
    logic             dec_invert;
    logic [PC_W-1:0]  dec_target;
    logic [CNT_W-1:0] dec_count;
    logic             dec_illegal;

    logic             flag_sel;
    logic             take_branch;
    logic             advance;
    logic             pc_last;

`ifdef COMALG_SEQ_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             wdog_expire;
    // wdog_q counts WAIT cycles from 0, so ERR lands WDOG_CYC cycles after the start pulse
    assign wdog_expire = (wdog_q == WdogW'(WDOG_CYC - 2));
`endif

    comalg_seq_dec #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) u_dec (
        .ir      (ir_q),
        .op      (dec_op),
        .cond    (dec_cond),
        .invert  (dec_invert),
        .target  (dec_target),
        .count   (dec_count),
        .illegal (dec_illegal)
    );

    assign pc_last = &pc_q;

    always_comb begin
        flag_sel = 1'b0;
        unique case (dec_cond)
            COND_ALWAYS: flag_sel = 1'b1;
            COND_ZERO:   flag_sel = status_q[STAT_ZERO];
            COND_CARRY:  flag_sel = status_q[STAT_CARRY];
            COND_ODD:    flag_sel = status_q[STAT_ODD];
        endcase
        take_branch = flag_sel ^ dec_invert;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        wlen_d   = wlen_q;
        mode_d   = mode_q;
        status_d = status_q;
        advance  = 1'b0;
`ifdef COMALG_SEQ_WDOG_EN
        wdog_d   = wdog_q;
`endif

        case (state_q)
            StIdle, StErr: begin
                if (seq_start) begin
                    wlen_d   = seq_wlen;
                    status_d = '0;
                    if (seq_wlen == '0) begin
                        state_d = StErr;
                    end else begin
                        pc_d    = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                ir_d    = seq_instr;
                state_d = StDecode;
            end
            StDecode: begin
                if (dec_illegal) begin
                    state_d = StErr;
                end else begin
                    case (dec_op)
                        OP_EXEC: begin
                            mode_d  = ir_q[5:0];
                            state_d = StIssue;
                        end
                        OP_BR: begin
                            if (take_branch) begin
                                pc_d    = dec_target;
                                state_d = StFetch;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        OP_LDCNT: begin
                            cnt_d   = dec_count;
                            advance = 1'b1;
                        end
                        OP_DJNZ: begin
                            // A zero counter falls through without wrapping
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - 1'b1;
                                if (cnt_q != CNT_W'(1)) begin
                                    pc_d    = dec_target;
                                    state_d = StFetch;
                                end else begin
                                    advance = 1'b1;
                                end
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        OP_HALT: state_d = StDone;
                        default: state_d = StErr;
                    endcase
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef COMALG_SEQ_WDOG_EN
                wdog_d  = '0;
`endif
            end
            StWait: begin
                if (comalg_end) begin
                    status_d = comalg_status;
                    advance  = 1'b1;
                end
`ifdef COMALG_SEQ_WDOG_EN
                else if (wdog_expire) begin
                    state_d = StErr;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Sequential fetch never wraps past the last program address
        if (advance) begin
            if (pc_last) begin
                state_d = StErr;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            wlen_q   <= '0;
            mode_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            wlen_q   <= wlen_d;
            mode_q   <= mode_d;
            status_q <= status_d;
        end
    end

`ifdef COMALG_SEQ_WDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign seq_busy     = (state_q == StFetch) || (state_q == StDecode) ||
                          (state_q == StIssue) || (state_q == StWait);
    assign seq_done     = (state_q == StDone);
    assign seq_error    = (state_q == StErr);
    assign seq_pc       = pc_q;
    assign seq_status   = status_q;
    assign comalg_wlen  = wlen_q;
    assign comalg_mode  = mode_q;
    assign comalg_start = (state_q == StIssue);

endmodule

// File: tb/tb_comalg_seq.sv
// Directed bench for comalg_seq: program ROM, latency model of com_alg, vector table.
module tb_comalg_seq;

    localparam logic [15:0] I_HALT = 16'hE000;
    localparam int          RSP_LAT = 20;
    localparam int          RUN_LIMIT = 3000;

    logic        clk;
    logic        reset;
    logic        seq_start;
    logic [7:0]  seq_wlen;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_error;
    logic [4:0]  seq_pc;
    logic [15:0] seq_instr;
    logic [2:0]  seq_status;
    logic [7:0]  comalg_wlen;
    logic [5:0]  comalg_mode;
    logic        comalg_start;
    logic        comalg_end;
    logic [2:0]  comalg_status;

    logic [15:0] rom [32];
    assign seq_instr = rom[seq_pc];

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_dones  = 0;

    bit          rsp_enable;
    logic [2:0]  rsp_status;
    int          rsp_count;
    logic [5:0]  issued_mode;
    logic        prev_start;
    logic        prev_done;

    comalg_seq #(
        .PC_W     (5),
        .CNT_W    (10),
        .WDOG_CYC (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seq_start     (seq_start),
        .seq_wlen      (seq_wlen),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .seq_error     (seq_error),
        .seq_pc        (seq_pc),
        .seq_instr     (seq_instr),
        .seq_status    (seq_status),
        .comalg_wlen   (comalg_wlen),
        .comalg_mode   (comalg_mode),
        .comalg_start  (comalg_start),
        .comalg_end    (comalg_end),
        .comalg_status (comalg_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] f_exec(input logic [5:0] m);
        return {3'b000, 7'b0, m};
    endfunction
    function automatic logic [15:0] f_br(input logic [1:0] c, input logic inv,
                                         input logic [4:0] t);
        return {3'b001, c, inv, 5'b0, t};
    endfunction
    function automatic logic [15:0] f_ldcnt(input logic [9:0] n);
        return {3'b010, 3'b0, n};
    endfunction
    function automatic logic [15:0] f_djnz(input logic [4:0] t);
        return {3'b011, 8'b0, t};
    endfunction

    function automatic logic [7:0][15:0] prog8(
        input logic [15:0] a0, input logic [15:0] a1 = I_HALT, input logic [15:0] a2 = I_HALT,
        input logic [15:0] a3 = I_HALT, input logic [15:0] a4 = I_HALT,
        input logic [15:0] a5 = I_HALT, input logic [15:0] a6 = I_HALT,
        input logic [15:0] a7 = I_HALT);
        logic [7:0][15:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    // com_alg model: end pulse RSP_LAT cycles after a start, carrying rsp_status
    initial begin
        comalg_end    = 1'b0;
        comalg_status = 3'b000;
        rsp_count     = 0;
        forever begin
            @(negedge clk);
            comalg_end = 1'b0;
            if (rsp_count > 0) begin
                rsp_count--;
                if (rsp_count == 0) begin
                    comalg_end    = 1'b1;
                    comalg_status = rsp_status;
                end
            end else if (comalg_start && rsp_enable && !reset) begin
                rsp_count = RSP_LAT;
            end
        end
    end

    initial begin
        prev_start  = 1'b0;
        prev_done   = 1'b0;
        issued_mode = '0;
        forever begin
            @(posedge clk);
            if (comalg_start) begin
                chk("start_pulse_width", prev_start, 0);
                n_starts++;
                issued_mode = comalg_mode;
            end
            if (comalg_end) begin
                chk("start_in_end_cycle", comalg_start, 0);
                chk("mode_held_until_end", comalg_mode, issued_mode);
            end
            if (seq_done) begin
                chk("done_pulse_width", prev_done, 0);
                n_dones++;
            end
            prev_start = comalg_start;
            prev_done  = seq_done;
        end
    end

    task automatic load_prog(input logic [7:0][15:0] p);
        for (int i = 0; i < 32; i++) rom[i] = (i < 8) ? p[i] : I_HALT;
    endtask

    task automatic run(input logic [7:0] wlen, output int starts, output int dones,
                       output int cycles, output bit to);
        int s0 = n_starts;
        int d0 = n_dones;
        @(negedge clk);
        seq_wlen  = wlen;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        cycles    = 0;
        while (!seq_done && !seq_error && cycles < RUN_LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        to = (cycles >= RUN_LIMIT);
        @(negedge clk);
        starts = n_starts - s0;
        dones  = n_dones - d0;
    endtask

    typedef struct {
        string            name;
        logic [7:0][15:0] prog;
        logic [7:0]       wlen;
        logic [2:0]       rsp;
        int               exp_starts;
        int               exp_dones;
        logic             exp_err;
        logic [2:0]       exp_status;
        logic [5:0]       exp_mode;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int  starts, dones, cycles, s0, k;
        bit  to;
        logic [25:0] outs;

        vecs[0]  = '{"exec_halt", prog8(f_exec(6'd0)), 8'd4, 3'b010, 1, 1, 1'b0, 3'b010, 6'd0};
        vecs[1]  = '{"djnz_loop", prog8(f_ldcnt(10'd3), f_exec(6'd3), f_djnz(5'd1)),
                     8'd4, 3'b001, 3, 1, 1'b0, 3'b001, 6'd3};
        vecs[2]  = '{"br_zero_taken", prog8(f_exec(6'd4), f_br(2'd1, 1'b0, 5'd3), I_HALT,
                     f_exec(6'd6)), 8'd4, 3'b001, 2, 1, 1'b0, 3'b001, 6'd6};
        vecs[3]  = '{"br_zero_not_taken", prog8(f_exec(6'd4), f_br(2'd1, 1'b0, 5'd3), I_HALT,
                     f_exec(6'd6)), 8'd4, 3'b000, 1, 1, 1'b0, 3'b000, 6'd4};
        vecs[4]  = '{"wlen_zero", prog8(f_exec(6'd1)), 8'd0, 3'b111, 0, 0, 1'b1, 3'b000, 6'd0};
        vecs[5]  = '{"illegal_pc0", prog8(16'h8000), 8'd4, 3'b111, 0, 0, 1'b1, 3'b000, 6'd0};
        vecs[6]  = '{"start_clears_err", prog8(f_exec(6'd1)), 8'd2, 3'b100, 1, 1, 1'b0,
                     3'b100, 6'd1};
        vecs[7]  = '{"br_never", prog8(f_br(2'd0, 1'b1, 5'd0)), 8'd3, 3'b000, 0, 1, 1'b0,
                     3'b000, 6'd0};
        vecs[8]  = '{"br_carry", prog8(f_exec(6'd0), f_br(2'd2, 1'b0, 5'd3), f_exec(6'd1)),
                     8'd5, 3'b010, 1, 1, 1'b0, 3'b010, 6'd0};
        vecs[9]  = '{"br_odd_inv", prog8(f_exec(6'd0), f_br(2'd3, 1'b1, 5'd3), f_exec(6'd2)),
                     8'd6, 3'b100, 2, 1, 1'b0, 3'b100, 6'd2};
        vecs[10] = '{"djnz_zero_entry", prog8(f_ldcnt(10'd0), f_djnz(5'd0), f_ldcnt(10'd1),
                     f_djnz(5'd0)), 8'd1, 3'b000, 0, 1, 1'b0, 3'b000, 6'd0};
        vecs[11] = '{"illegal_mid", prog8(f_exec(6'd5), f_ldcnt(10'd2), 16'hC000), 8'd7,
                     3'b111, 1, 0, 1'b1, 3'b111, 6'd5};

        reset      = 1'b1;
        seq_start  = 1'b0;
        seq_wlen   = 8'd0;
        rsp_enable = 1'b1;
        rsp_status = 3'b000;
        load_prog(prog8(I_HALT));
        repeat (3) @(negedge clk);
        outs = {seq_busy, seq_done, seq_error, seq_pc, seq_status, comalg_wlen, comalg_mode,
                comalg_start};
        chk("reset_outputs", outs, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", seq_busy, 0);

        for (int i = 0; i < 12; i++) begin
            rsp_status = vecs[i].rsp;
            load_prog(vecs[i].prog);
            run(vecs[i].wlen, starts, dones, cycles, to);
            chk({vecs[i].name, ".timeout"}, to, 0);
            chk({vecs[i].name, ".starts"}, starts, vecs[i].exp_starts);
            chk({vecs[i].name, ".dones"}, dones, vecs[i].exp_dones);
            chk({vecs[i].name, ".error"}, seq_error, vecs[i].exp_err);
            chk({vecs[i].name, ".status"}, seq_status, vecs[i].exp_status);
            chk({vecs[i].name, ".busy"}, seq_busy, 0);
            chk({vecs[i].name, ".wlen"}, comalg_wlen, vecs[i].wlen);
            if (vecs[i].exp_starts > 0) chk({vecs[i].name, ".mode"}, comalg_mode,
                                            vecs[i].exp_mode);
        end

        // wlen=0 must raise the error in the cycle right after start
        load_prog(prog8(f_exec(6'd0)));
        run(8'd0, starts, dones, cycles, to);
        chk("wlen0.latency", cycles, 0);
        chk("wlen0.error", seq_error, 1);
        chk("wlen0.starts", starts, 0);

        // Sequential fetch past the last address is an error, not a wrap
        load_prog(prog8(f_br(2'd0, 1'b0, 5'd31)));
        rom[31] = f_ldcnt(10'd0);
        run(8'd2, starts, dones, cycles, to);
        chk("pc_overflow.error", seq_error, 1);
        chk("pc_overflow.dones", dones, 0);

        // Reset while waiting on com_alg
        rsp_enable = 1'b0;
        load_prog(prog8(f_exec(6'd3)));
        s0 = n_starts;
        @(negedge clk);
        seq_wlen  = 8'd4;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        k = 0;
        while (!comalg_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_wait.reached_issue", comalg_start, 1);
        repeat (5) @(negedge clk);
        chk("rst_wait.busy", seq_busy, 1);
        reset = 1'b1;
        #1;
        outs = {seq_busy, seq_done, seq_error, seq_pc, seq_status, comalg_wlen, comalg_mode,
                comalg_start};
        chk("rst_wait.outputs", outs, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait.start_in_reset", comalg_start, 0);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_wait.start_count", n_starts - s0, 1);
        chk("rst_wait.idle_busy", seq_busy, 0);

`ifdef COMALG_SEQ_WDOG_EN
        load_prog(prog8(f_exec(6'd2)));
        @(negedge clk);
        seq_wlen  = 8'd4;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        k = 0;
        while (!comalg_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wdog.reached_issue", comalg_start, 1);
        k = 0;
        while (!seq_error && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wdog.latency", k, 16);
        chk("wdog.status", seq_status, 3'b000);
`endif

        rsp_enable = 1'b1;
        rsp_status = vecs[0].rsp;
        load_prog(vecs[0].prog);
        run(vecs[0].wlen, starts, dones, cycles, to);
        chk("recover.starts", starts, 1);
        chk("recover.dones", dones, 1);
        chk("recover.error", seq_error, 0);
        chk("recover.status", seq_status, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 500000 time units");
        $fatal(1, "global timeout");
    end

endmodule
